mnist_input_binarizer: RTL and testbench



---
 rtl/mnist_input_binarizer.sv | 116 +++++++++++
 tb/tb_mnist_input_binarizer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mnist_input_binarizer.sv
// Streaming pixel binarizer for the MNIST LogicNets front end.
// Each accepted pixel is compared against THRESHOLD and the result is packed
// into a frame-wide bit vector. Completed frames move to a separate output
// register, so the consumer never observes a partially assembled frame.
// Framing errors (an early or missing in_last) are flagged with a one-cycle
// pulse and counted in a saturating counter.
module mnist_input_binarizer #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned PIXEL_W    = 8,
    parameter int unsigned THRESHOLD  = 128,
    parameter int unsigned ERR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIXEL_W-1:0]    in_pixel,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_PIXELS-1:0] out_bits,
    output logic                  err_pulse,
    output logic [ERR_W-1:0]      err_count
);

    localparam int unsigned IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PIXELS - 1);
    localparam logic [PIXEL_W-1:0] THR      = PIXEL_W'(THRESHOLD);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_PIXELS-1:0]   asm_q, asm_d;
    logic [NUM_PIXELS-1:0]   out_bits_q, out_bits_d;
    logic                    err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]        err_count_q, err_count_d;

    logic                    in_ready_c;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    frame_err;

    // State register and datapath flops, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            asm_q       <= '0;
            out_bits_q  <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            out_bits_q  <= out_bits_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    // Handshakes, pixel assembly, frame hand-off and framing-error tracking
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        out_bits_d  = out_bits_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        frame_err   = 1'b0;

        // In HOLD a new pixel may enter only in the cycle the held frame leaves
        in_ready_c = (state_q == FILL) || out_ready;
        in_xfer    = in_valid && in_ready_c;
        out_xfer   = (state_q == HOLD) && out_ready;

        if (out_xfer) begin
            state_d = FILL;
        end

        if (in_xfer) begin
            asm_d[idx_q] = (in_pixel >= THR);
            if (idx_q == LAST_IDX) begin
                // Full frame: deliver it even when in_last was missing
                idx_d      = '0;
                out_bits_d = asm_d;
                state_d    = HOLD;
                frame_err  = !in_last;
            end else if (in_last) begin
                // Early last: drop the partial frame and restart at index 0
                idx_d     = '0;
                frame_err = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (frame_err) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = (state_q == HOLD);
    assign out_bits  = out_bits_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mnist_input_binarizer.sv
// Directed testbench for mnist_input_binarizer with a 16-pixel frame and a
// 2-bit error counter so saturation is reachable with a handful of frames.
module tb_mnist_input_binarizer;

    localparam int unsigned NP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [NP-1:0] out_bits;
    logic          err_pulse;
    logic [1:0]    err_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    int pulses   = 0;

    mnist_input_binarizer #(
        .NUM_PIXELS(NP),
        .PIXEL_W   (8),
        .THRESHOLD (128),
        .ERR_W     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pixel (in_pixel),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits (out_bits),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  ev;
        logic [7:0]  od;
        int          n;
        int          last_at;
        logic        exp_valid;
        logic [15:0] exp_bits;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive pixels p0..n-1 (even/odd pattern), one per cycle, from the falling edge.
    task automatic send_frame(input logic [7:0] ev, input logic [7:0] od,
                              input int p0, input int n, input int last_at);
        for (int p = p0; p < n; p++) begin
            @(negedge clk);
            check("out_valid_low_while_filling", {31'b0, out_valid}, 32'd0);
            in_valid = 1'b1;
            in_pixel = (p % 2 == 0) ? ev : od;
            in_last  = (p == last_at);
            #1;
            check("in_ready_fill", {31'b0, in_ready}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic note_err(input logic e);
        if (e && exp_cnt < 3) exp_cnt++;
    endtask

    initial begin
        tbl[0] = '{8'h80, 8'h7F, 16, 15,  1'b1, 16'h5555, 1'b0};
        tbl[1] = '{8'hFF, 8'hFF, 16, -1,  1'b1, 16'hFFFF, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 16, 15,  1'b1, 16'h0000, 1'b0};
        tbl[3] = '{8'h80, 8'h7F, 6,  5,   1'b0, 16'h0000, 1'b1};
        tbl[4] = '{8'h00, 8'hFF, 16, 15,  1'b1, 16'hAAAA, 1'b0};
        tbl[5] = '{8'hFF, 8'h00, 1,  0,   1'b0, 16'h0000, 1'b1};
        tbl[6] = '{8'hC0, 8'h3F, 16, 15,  1'b1, 16'h5555, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_bits", {16'b0, out_bits}, 32'd0);
        check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
        check("rst_err_count", {30'b0, err_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Table-driven frames, consumer always ready
        for (int v = 0; v < 7; v++) begin
            send_frame(tbl[v].ev, tbl[v].od, 0, tbl[v].n, tbl[v].last_at);
            note_err(tbl[v].exp_err);
            check($sformatf("vec%0d_out_valid", v), {31'b0, out_valid}, {31'b0, tbl[v].exp_valid});
            if (tbl[v].exp_valid)
                check($sformatf("vec%0d_out_bits", v), {16'b0, out_bits}, {16'b0, tbl[v].exp_bits});
            check($sformatf("vec%0d_err_pulse", v), {31'b0, err_pulse}, {31'b0, tbl[v].exp_err});
            check($sformatf("vec%0d_err_count", v), {30'b0, err_count}, exp_cnt);
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", v), {31'b0, out_valid}, 32'd0);
            check($sformatf("vec%0d_pulse_once", v), {31'b0, err_pulse}, 32'd0);
        end

        // Backpressure: frame held for 10 cycles, then consumed while pixel 0 enters
        out_ready = 1'b0;
        send_frame(8'h80, 8'h7F, 0, 16, 15);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_bits", {16'b0, out_bits}, 32'h5555);
            check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pixel  = 8'hFF;
        in_last   = 1'b0;
        #1;
        check("bp_in_ready_follows", {31'b0, in_ready}, 32'd1);
        send_frame(8'h00, 8'h00, 1, 16, 15);
        check("bp_next_valid", {31'b0, out_valid}, 32'd1);
        check("bp_next_bits", {16'b0, out_bits}, 32'h0001);
        check("bp_next_count", {30'b0, err_count}, exp_cnt);
        @(negedge clk);

        // Reset in the middle of a frame
        send_frame(8'hFF, 8'hFF, 0, 9, -1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_bits", {16'b0, out_bits}, 32'd0);
        check("mid_rst_err_count", {30'b0, err_count}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h00, 8'hFF, 0, 16, 15);
        check("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_bits", {16'b0, out_bits}, 32'hAAAA);
        check("post_rst_count", {30'b0, err_count}, 32'd0);
        @(negedge clk);

        // Five early-last frames: counter saturates at 3, pulse every time
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'hFF, 8'hFF, 0, 6, 5);
            note_err(1'b1);
            if (err_pulse === 1'b1) pulses++;
            check($sformatf("sat%0d_no_valid", k), {31'b0, out_valid}, 32'd0);
            check($sformatf("sat%0d_err_count", k), {30'b0, err_count}, exp_cnt);
            @(negedge clk);
            check($sformatf("sat%0d_pulse_once", k), {31'b0, err_pulse}, 32'd0);
        end
        check("sat_pulse_total", pulses, 32'd5);
        check("sat_final_count", {30'b0, err_count}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
